// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared widths, digit positions, limits and debounce states
//
// Purpose: common definitions for keypad time entry (digit/key widths, the six
// HH:MM:SS digit positions, the largest legal digit at each position, the
// debounce state encoding) plus small helpers for one-hot decoding and limits.
// Ports: none (package).

package watch_pkg;

  localparam int DIGIT_W    = 4;
  localparam int KEY_W      = 10;
  localparam int NUM_DIGITS = 6;

  // Entry order: hours tens first, seconds ones last.
  localparam logic [2:0] POS_H_TEN = 3'd0;
  localparam logic [2:0] POS_H_ONE = 3'd1;
  localparam logic [2:0] POS_M_TEN = 3'd2;
  localparam logic [2:0] POS_M_ONE = 3'd3;
  localparam logic [2:0] POS_S_TEN = 3'd4;
  localparam logic [2:0] POS_S_ONE = 3'd5;

  localparam logic [DIGIT_W-1:0] MAX_H_TEN    = 4'd2;
  localparam logic [DIGIT_W-1:0] MAX_H_ONE    = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_H_ONE_20 = 4'd3;  // hours 20..23 only
  localparam logic [DIGIT_W-1:0] MAX_M_TEN    = 4'd5;
  localparam logic [DIGIT_W-1:0] MAX_M_ONE    = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_S_TEN    = 4'd5;
  localparam logic [DIGIT_W-1:0] MAX_S_ONE    = 4'd9;

  typedef enum logic [1:0] {
    K_IDLE  = 2'd0,
    K_PRESS = 2'd1,
    K_HELD  = 2'd2,
    K_REL   = 2'd3
  } key_state_t;

  // True when exactly one key bit is set.
  function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

  // Index of the set bit of a one-hot key pattern.
  function automatic logic [DIGIT_W-1:0] onehot_to_digit(input logic [KEY_W-1:0] v);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (v[i]) d = i[DIGIT_W-1:0];
    end
    return d;
  endfunction

  // Largest digit allowed at position p; the hours ones digit depends on
  // the already staged hours tens digit.
  function automatic logic [DIGIT_W-1:0] max_digit(input logic [2:0]         p,
                                                   input logic [DIGIT_W-1:0] h_ten);
    logic [DIGIT_W-1:0] m;
    case (p)
      POS_H_TEN: m = MAX_H_TEN;
      POS_H_ONE: m = (h_ten == 4'd2) ? MAX_H_ONE_20 : MAX_H_ONE;
      POS_M_TEN: m = MAX_M_TEN;
      POS_M_ONE: m = MAX_M_ONE;
      POS_S_TEN: m = MAX_S_TEN;
      POS_S_ONE: m = MAX_S_ONE;
      default:   m = 4'd9;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - keypad synchronizer, one-hot check and debounce FSM
//
// Purpose: synchronizes the raw 10-key keypad, accepts a press only after
// DEBOUNCE_CYC identical one-hot samples and re-arms only after DEBOUNCE_CYC
// all-zero samples, so one physical press yields exactly one key_valid.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   key           raw keypad, asynchronous
//   key_valid     registered one-cycle pulse per accepted press
//   key_digit     registered digit of the last accepted press
//   accept        combinational: key_valid will pulse after this edge
//   accept_digit  combinational: digit that key_digit will take on accept

module key_debounce
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_W-1:0]   key,
  output logic               key_valid,
  output logic [DIGIT_W-1:0] key_digit,
  output logic               accept,
  output logic [DIGIT_W-1:0] accept_digit
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [KEY_W-1:0] sync1, sync2;
  logic [KEY_W-1:0] pattern, pattern_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  key_state_t       state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      pattern   <= '0;
      cnt       <= '0;
      state     <= K_IDLE;
      key_valid <= 1'b0;
      key_digit <= '0;
    end else begin
      sync1     <= key;
      sync2     <= sync1;
      pattern   <= pattern_nxt;
      cnt       <= cnt_nxt;
      state     <= state_nxt;
      key_valid <= accept;
      if (accept) key_digit <= accept_digit;
    end
  end

  // The sample that moves the FSM out of K_IDLE (or K_HELD) is the first of
  // the DEBOUNCE_CYC consecutive samples, hence the counter restarts at 1.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pattern_nxt = pattern;
    accept      = 1'b0;
    case (state)
      K_IDLE: begin
        cnt_nxt = '0;
        if (is_one_hot(sync2)) begin
          pattern_nxt = sync2;
          cnt_nxt     = CNT_W'(1);
          state_nxt   = K_PRESS;
        end
      end
      K_PRESS: begin
        if (sync2 != pattern) begin
          cnt_nxt   = '0;
          state_nxt = K_IDLE;
        end else if (cnt == CNT_LAST) begin
          accept    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = K_HELD;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      K_HELD: begin
        if (sync2 == '0) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = K_REL;
        end
      end
      K_REL: begin
        if (sync2 != '0) begin
          cnt_nxt   = '0;
          state_nxt = K_HELD;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = K_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = K_IDLE;
      end
    endcase
  end

  assign accept_digit = onehot_to_digit(pattern);

endmodule

// File: rtl/keypad_time_entry.sv
// rtl/keypad_time_entry.sv - keypad HH:MM:SS entry with per-position validation
//
// Purpose: collects six debounced, range-checked digits into a packed BCD
// time and presents it with a one-cycle load strobe for the watch time-set.
// Ports:
//   clk, rst   1 kHz system clock, synchronous active-high reset
//   start      begin/restart entry (level, sampled each cycle)
//   clear      abort entry without loading
//   key        raw one-hot keypad, asynchronous
//   key_valid  one-cycle pulse per accepted press
//   key_digit  digit of the last accepted press
//   rejected   one-cycle pulse when the press is illegal for pos
//   pos        index of the next digit, 0 = h_ten .. 5 = s_one
//   busy       entry in progress
//   load       one-cycle pulse when six digits are complete
//   time_bcd   {h_ten,h_one,m_ten,m_one,s_ten,s_one}

module keypad_time_entry
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          clear,
  input  logic [KEY_W-1:0]              key,
  output logic                          key_valid,
  output logic [DIGIT_W-1:0]            key_digit,
  output logic                          rejected,
  output logic [2:0]                    pos,
  output logic                          busy,
  output logic                          load,
  output logic [NUM_DIGITS*DIGIT_W-1:0] time_bcd
);

  localparam int TIME_W = NUM_DIGITS * DIGIT_W;

  logic               accept;
  logic [DIGIT_W-1:0] accept_digit;
  logic [TIME_W-1:0]  staging, staging_nxt;
  logic               over_limit;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk          (clk),
    .rst          (rst),
    .key          (key),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .accept       (accept),
    .accept_digit (accept_digit)
  );

  // Decisions are taken on the edge that raises key_valid, so rejected and
  // load line up with key_valid rather than trailing it by a cycle.
  assign over_limit = accept_digit > max_digit(pos, staging[TIME_W-1 -: DIGIT_W]);

  always_comb begin
    staging_nxt = staging;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (pos == i[2:0]) staging_nxt[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = accept_digit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      pos      <= '0;
      staging  <= '0;
      time_bcd <= '0;
      load     <= 1'b0;
      rejected <= 1'b0;
    end else begin
      load     <= 1'b0;
      rejected <= 1'b0;
      if (clear) begin
        busy <= 1'b0;
        pos  <= '0;
      end else if (start) begin
        busy    <= 1'b1;
        pos     <= '0;
        staging <= '0;
      end else if (accept && busy) begin
        if (over_limit) begin
          rejected <= 1'b1;
        end else if (pos == POS_S_ONE) begin
          staging  <= staging_nxt;
          time_bcd <= staging_nxt;
          load     <= 1'b1;
          busy     <= 1'b0;
          pos      <= '0;
        end else begin
          staging <= staging_nxt;
          pos     <= pos + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_time_entry.sv
// tb/tb_keypad_time_entry.sv - scoreboard bench for keypad_time_entry

module tb_keypad_time_entry;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [9:0]  key = '0;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        rejected;
  logic [2:0]  pos;
  logic        busy;
  logic        load;
  logic [23:0] time_bcd;

  keypad_time_entry #(.DEBOUNCE_CYC(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clear     (clear),
    .key       (key),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .rejected  (rejected),
    .pos       (pos),
    .busy      (busy),
    .load      (load),
    .time_bcd  (time_bcd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0]  digit;
    logic        rej;
    logic        ld;
    logic [23:0] bcd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   kv_count = 0;
  int   kv_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every key_valid pops one expected press from the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) begin
        kv_count++;
        kv_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key_valid: got digit %0d expected no press", key_digit);
        end else begin
          mon_e = sb.pop_front();
          chk("key_digit", key_digit, mon_e.digit);
          chk("rejected", rejected, mon_e.rej);
          chk("load", load, mon_e.ld);
          if (mon_e.ld) chk("time_bcd_at_load", time_bcd, mon_e.bcd);
        end
      end else if (rejected || load) begin
        checks++;
        errors++;
        $display("FAIL stray_strobe: got rejected=%0b load=%0b expected 0 0", rejected, load);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_press(input int d, input logic rej, input logic ld, input logic [23:0] bcd);
    exp_t e;
    e.digit = d[3:0];
    e.rej   = rej;
    e.ld    = ld;
    e.bcd   = bcd;
    sb.push_back(e);
  endtask

  task automatic drain_check(input string name);
    chk(name, sb.size(), 0);
    while (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic press(input int d, input logic rej, input logic ld, input logic [23:0] bcd);
    expect_press(d, rej, ld, bcd);
    key = '0;
    key[d] = 1'b1;
    tick(10);
    key = '0;
    tick(10);
    drain_check("press_seen");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kv0;
    int t0;

    // 1: reset with every key down
    rst = 1'b1;
    key = 10'h3FF;
    tick(3);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_digit", key_digit, 0);
    chk("rst_rejected", rejected, 0);
    chk("rst_pos", pos, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load", load, 0);
    chk("rst_time_bcd", time_bcd, 0);
    rst = 1'b0;
    tick(20);
    chk("multikey_no_valid", kv_count, 0);
    key = '0;
    tick(10);

    // 2: full entry 23:59:59
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_pos", pos, 0);
    press(2, 0, 0, 0);
    press(3, 0, 0, 0);
    press(5, 0, 0, 0);
    chk("pos_after_3", pos, 3);
    press(9, 0, 0, 0);
    press(5, 0, 0, 0);
    press(9, 0, 1, 24'h235959);
    chk("s2_time_bcd", time_bcd, 24'h235959);
    chk("s2_busy", busy, 0);
    chk("s2_pos", pos, 0);

    // 3: bouncing key 7, then stable hold
    kv0 = kv_count;
    for (int i = 0; i < 6; i++) begin
      key[7] = ~key[7];
      tick(2);
    end
    chk("bounce_no_valid", kv_count - kv0, 0);
    expect_press(7, 0, 0, 0);
    key = '0;
    key[7] = 1'b1;
    t0 = cyc;
    tick(10);
    chk("bounce_one_valid", kv_count - kv0, 1);
    chk("bounce_latency", kv_cyc - t0, DEB + 2);
    chk("bounce_digit", key_digit, 7);
    key = '0;
    tick(10);
    drain_check("bounce_seen");

    // 4: position limits
    pulse_start();
    press(3, 1, 0, 0);
    chk("rej_h_ten_pos", pos, 0);
    press(2, 0, 0, 0);
    chk("h_ten_pos", pos, 1);
    press(4, 1, 0, 0);
    chk("rej_h_one_pos", pos, 1);
    press(3, 0, 0, 0);
    chk("h_one_pos", pos, 2);
    pulse_clear();
    chk("s4_clear_busy", busy, 0);

    // 5: two keys together, then release one
    kv0 = kv_count;
    key = '0;
    key[1] = 1'b1;
    key[4] = 1'b1;
    tick(30);
    chk("two_keys_no_valid", kv_count - kv0, 0);
    expect_press(1, 0, 0, 0);
    key[4] = 1'b0;
    t0 = cyc;
    tick(10);
    chk("single_after_two_valid", kv_count - kv0, 1);
    chk("single_after_two_latency", kv_cyc - t0, DEB + 2);
    key = '0;
    tick(10);
    drain_check("two_keys_seen");

    // 6: abort with clear, then a fresh entry
    pulse_start();
    press(1, 0, 0, 0);
    press(2, 0, 0, 0);
    press(0, 0, 0, 0);
    chk("s6_pos_before_clear", pos, 3);
    pulse_clear();
    chk("clear_busy", busy, 0);
    chk("clear_pos", pos, 0);
    tick(5);
    chk("clear_keeps_time", time_bcd, 24'h235959);
    pulse_start();
    press(0, 0, 0, 0);
    press(0, 0, 0, 0);
    press(0, 0, 0, 0);
    press(0, 0, 0, 0);
    press(0, 0, 0, 0);
    press(1, 0, 1, 24'h000001);
    chk("s6_time_bcd", time_bcd, 24'h000001);
    chk("s6_busy", busy, 0);

    drain_check("final_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
